// File: rtl/shifter_pkg.sv
// Shared encodings, state constants and default widths for the iterative shifter.
package shifter_pkg;

    localparam int unsigned SHIFT_W     = 16;
    localparam int unsigned SHIFT_CNT_W = 4;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    typedef logic [1:0] shifter_iter_state_t;

    localparam shifter_iter_state_t IDLE  = 2'd0;
    localparam shifter_iter_state_t SHIFT = 2'd1;
    localparam shifter_iter_state_t DONE  = 2'd2;

endpackage

// File: rtl/shift_one_step.sv
// Combinational single-bit shift/rotate: one level of the iterative shifter datapath.
module shift_one_step
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = SHIFT_W
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       op_i,
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        unique case (op_i)
            OP_ROL: data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
            OP_SLL: data_o = {data_i[WIDTH-2:0], 1'b0};
            OP_SRA: data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
            OP_SRL: data_o = {1'b0, data_i[WIDTH-1:1]};
        endcase
    end

endmodule

// File: rtl/shifter_iter.sv
// Iterative shifter: one (or two with SHIFTER_ITER_DOUBLE_EN) single-bit steps per cycle,
// valid/ready on both sides.
module shifter_iter
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = SHIFT_W,
    parameter int unsigned CNT_W = SHIFT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0] cnt,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out
);

    shifter_iter_state_t state_q, state_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [1:0]          op_q, op_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0]    step1;

    shift_one_step #(.WIDTH(WIDTH)) u_step0 (
        .data_i (data_q),
        .op_i   (op_q),
        .data_o (step1)
    );

`ifdef SHIFTER_ITER_DOUBLE_EN
    logic [WIDTH-1:0] step2;

    shift_one_step #(.WIDTH(WIDTH)) u_step1 (
        .data_i (step1),
        .op_i   (op_q),
        .data_o (step2)
    );
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        op_d    = op_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = data_in;
                    op_d    = op;
                    rem_d   = cnt;
                    state_d = (cnt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
`ifdef SHIFTER_ITER_DOUBLE_EN
                if (rem_q >= CNT_W'(2)) begin
                    data_d = step2;
                    rem_d  = rem_q - CNT_W'(2);
                end else begin
                    data_d = step1;
                    rem_d  = '0;
                end
                if (rem_q <= CNT_W'(2)) begin
                    state_d = DONE;
                end
`else
                data_d = step1;
                rem_d  = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            op_q    <= OP_ROL;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign data_out  = data_q;

endmodule

// File: tb/tb_shifter_iter.sv
// Directed self-checking bench for shifter_iter; honours SHIFTER_ITER_DOUBLE_EN for latency.
module tb_shifter_iter;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data_in;
    logic [3:0]  cnt;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] data_out;

    int total;
    int bad;
    int lat;

    shifter_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .cnt       (cnt),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input int c);
`ifdef SHIFTER_ITER_DOUBLE_EN
        return 1 + (c + 1) / 2;
`else
        return 1 + c;
`endif
    endfunction

    // Call just after a negedge; returns just after the accept edge with garbage on the inputs.
    task automatic issue(input logic [1:0] o, input logic [15:0] d, input logic [3:0] c);
        op       = o;
        data_in  = d;
        cnt      = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_in  = 16'hDEAD;
        cnt      = 4'hF;
        op       = ~o;
    endtask

    // Counts negedges after the accept edge until out_valid; 0 if the bound expires.
    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        data_in   = '0;
        cnt       = '0;
        op        = '0;
        out_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data_out", {16'd0, data_out}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // 1: ROL 0x8001 by 1
        issue(2'b00, 16'h8001, 4'd1);
        wait_valid(lat);
        chk("rol1_lat", lat, exp_lat(1));
        chk("rol1_data", {16'd0, data_out}, 32'h0003);
        handoff();

        // 2: SLL 0x00F0 by 4, inputs scrambled while shifting
        @(negedge clk);
        issue(2'b01, 16'h00F0, 4'd4);
        @(negedge clk);
        chk("sll4_busy_in_ready", {31'd0, in_ready}, 32'd0);
        wait_valid(lat);
        chk("sll4_lat", lat + 1, exp_lat(4));
        chk("sll4_data", {16'd0, data_out}, 32'h0F00);
        chk("sll4_done_in_ready", {31'd0, in_ready}, 32'd0);
        handoff();

        // 3: SRA and SRL of 0x8000 by 15
        issue(2'b10, 16'h8000, 4'd15);
        wait_valid(lat);
        chk("sra15_lat", lat, exp_lat(15));
        chk("sra15_data", {16'd0, data_out}, 32'hFFFF);
        handoff();
        issue(2'b11, 16'h8000, 4'd15);
        wait_valid(lat);
        chk("srl15_lat", lat, exp_lat(15));
        chk("srl15_data", {16'd0, data_out}, 32'h0001);
        handoff();

        // 4: zero count passes the operand through
        issue(2'b10, 16'hA5A5, 4'd0);
        wait_valid(lat);
        chk("cnt0_lat", lat, 1);
        chk("cnt0_data", {16'd0, data_out}, 32'hA5A5);
        handoff();

        // 5: backpressure with competing requests
        issue(2'b01, 16'h091A, 4'd1);
        wait_valid(lat);
        chk("bp_lat", lat, exp_lat(1));
        in_valid = 1'b1;
        data_in  = 16'h5555;
        cnt      = 4'd0;
        op       = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_data", {16'd0, data_out}, 32'h1234);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_handoff_not_taken", {31'd0, in_ready}, 32'd1);
        chk("bp_handoff_out_valid", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);

        // 6: reset abort mid-shift, then a fresh request
        issue(2'b11, 16'hFFFF, 4'd10);
        repeat (3) @(negedge clk);
        chk("abort_busy", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_data", {16'd0, data_out}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_idle_out_valid", {31'd0, out_valid}, 32'd0);
        issue(2'b00, 16'h0001, 4'd3);
        wait_valid(lat);
        chk("post_rol3_lat", lat, exp_lat(3));
        chk("post_rol3_data", {16'd0, data_out}, 32'h0008);
        handoff();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
